data_memory_bytelane: RTL and testbench

- Parametrised successor to the single-cycle word data memory in the RV32I datapath; sits between the ALU address output and the writeback mux.
- Byte-addressed, with RV32I load/store sizing (LB/LH/LW/LBU/LHU/SB/SH/SW) and byte-lane writes.
- Registered read data with a valid strobe; misalignment and access-error detection.
- Hardware init walk after reset, so contents are deterministic without simulation-only initial blocks.

---
 rtl/data_memory_bytelane.sv | 174 +++++++++++++++++
 tb/tb_data_memory_bytelane.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_bytelane
// Purpose  : Byte-addressed RV32I data memory with sized loads/stores, a
//            registered read path and a post-reset init walk (mem[i] = i).
//            Optional macro DMEM_DEBUG_PORT_EN adds a combinational debug read.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_bytelane #(
    parameter int DEPTH      = 32,
    parameter int RESET_INIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        access_err
`ifdef DMEM_DEBUG_PORT_EN
    ,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [31:0]              dbg_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = (RESET_INIT != 0) ? ST_INIT : ST_IDLE;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state, w_state_next;
    logic [AW-1:0] r_init_cnt, w_init_cnt_next;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_ext;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_store, w_load;
    logic          w_range_err, w_f3_err, w_err, w_misal, w_do_write;

    // ------------------------------------------------------------------
    // Init-walk state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_RESET_STATE;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        busy            = 1'b0;
        if (r_state == ST_INIT) begin
            busy            = 1'b1;
            w_init_cnt_next = r_init_cnt + 1'b1;
            if (r_init_cnt == c_LAST_IDX) begin
                w_state_next = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_idx       = addr[AW+1:2];
        w_store     = mem_write & ~busy;
        w_load      = mem_read & ~mem_write & ~busy;
        w_range_err = |addr[31:AW+2];
        // Loads reject 011/110/111; stores reject anything above SW.
        w_f3_err    = mem_write ? (funct3 >= 3'd3)
                                : ((funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11));
        w_err       = w_range_err | w_f3_err;
        w_misal     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_do_write  = w_store & ~w_err & ~w_misal;

        w_be    = 4'b1111;
        w_wdata = write_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_word = r_mem[w_idx];
        case (addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = addr[1] ? w_word[31:16] : w_word[15:0];
        case (funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_ext = w_word;
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: the init walk owns the write port until it finishes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= {{(32-AW){1'b0}}, r_init_cnt};
        end else if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered responses and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= 32'd0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            access_err <= 1'b0;
        end else begin
            rd_valid   <= w_load;
            misaligned <= (w_store | w_load) & w_misal & ~w_err;
            access_err <= (w_store | w_load) & w_err;
            if (w_load) begin
                read_data <= (w_err | w_misal) ? 32'd0 : w_load_ext;
            end
        end
    end

`ifdef DMEM_DEBUG_PORT_EN
    assign dbg_data = r_mem[dbg_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_bytelane
// Purpose  : Directed self-checking bench for data_memory_bytelane (DEPTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_bytelane;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        busy;
    logic        misaligned;
    logic        access_err;

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_bytelane #(
        .DEPTH      (32),
        .RESET_INIT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .misaligned (misaligned),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request cycle; outputs are observed 1 ns after the sampling edge.
    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        write_data = wd;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    int busy_cycles;

    initial begin
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b1;        // held high across the walk; must be ignored
        funct3     = 3'b010;
        addr       = 32'h0000_0000;
        write_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_data",  read_data, 32'd0);
        chk("rst_rd_valid",   {31'd0, rd_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_access_err", {31'd0, access_err}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd1);

        // Release, then abort the walk after 10 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_walk_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reassert_busy",     {31'd0, busy}, 32'd1);
        chk("reassert_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reassert_rdata",    read_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(busy_cycles);
        mem_write = 1'b0;
        chk("busy_cycles", busy_cycles, 32'd32);

        // Init contents and the dropped held-high store.
        req(1'b1, 1'b0, 3'b010, 32'h7C, 32'd0);
        chk("lw_7c",       read_data, 32'h0000_001F);
        chk("lw_7c_valid", {31'd0, rd_valid}, 32'd1);
        req(1'b1, 1'b0, 3'b010, 32'h00, 32'd0);
        chk("lw_00_init",  read_data, 32'h0000_0000);
        req(1'b0, 1'b0, 3'b000, 32'h00, 32'd0);
        chk("idle_valid",  {31'd0, rd_valid}, 32'd0);
        chk("idle_hold",   read_data, 32'h0000_0000);

        // Sized loads with sign/zero extension.
        req(1'b0, 1'b1, 3'b010, 32'h10, 32'h8AD3_4DF1);
        chk("sw_no_valid", {31'd0, rd_valid}, 32'd0);
        req(1'b1, 1'b0, 3'b000, 32'h13, 32'd0);
        chk("lb_13",  read_data, 32'hFFFF_FF8A);
        req(1'b1, 1'b0, 3'b100, 32'h13, 32'd0);
        chk("lbu_13", read_data, 32'h0000_008A);
        req(1'b1, 1'b0, 3'b001, 32'h12, 32'd0);
        chk("lh_12",  read_data, 32'hFFFF_8AD3);
        req(1'b1, 1'b0, 3'b101, 32'h12, 32'd0);
        chk("lhu_12", read_data, 32'h0000_8AD3);
        req(1'b1, 1'b0, 3'b000, 32'h10, 32'd0);
        chk("lb_10",  read_data, 32'hFFFF_FFF1);
        req(1'b1, 1'b0, 3'b001, 32'h10, 32'd0);
        chk("lh_10",  read_data, 32'h0000_4DF1);

        // Byte and halfword lane writes over init value 8.
        req(1'b0, 1'b1, 3'b000, 32'h21, 32'h1122_33AA);
        req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        chk("sb_lw_20", read_data, 32'h0000_AA08);
        req(1'b0, 1'b1, 3'b001, 32'h22, 32'h5678_1234);
        req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        chk("sh_lw_20", read_data, 32'h1234_AA08);

        // Misalignment.
        req(1'b0, 1'b1, 3'b010, 32'h06, 32'hFFFF_FFFF);
        chk("sw_06_mis",   {31'd0, misaligned}, 32'd1);
        chk("sw_06_err",   {31'd0, access_err}, 32'd0);
        req(1'b1, 1'b0, 3'b001, 32'h05, 32'd0);
        chk("lh_05_mis",   {31'd0, misaligned}, 32'd1);
        chk("lh_05_valid", {31'd0, rd_valid}, 32'd1);
        chk("lh_05_data",  read_data, 32'd0);
        req(1'b1, 1'b0, 3'b010, 32'h04, 32'd0);
        chk("lw_04_intact", read_data, 32'h0000_0001);
        chk("lw_04_mis",    {31'd0, misaligned}, 32'd0);

        // Access errors.
        req(1'b1, 1'b0, 3'b010, 32'h80, 32'd0);
        chk("lw_80_err",   {31'd0, access_err}, 32'd1);
        chk("lw_80_valid", {31'd0, rd_valid}, 32'd1);
        chk("lw_80_data",  read_data, 32'd0);
        req(1'b0, 1'b1, 3'b011, 32'h04, 32'hCAFE_F00D);
        chk("st_f3_011_err", {31'd0, access_err}, 32'd1);
        req(1'b1, 1'b0, 3'b010, 32'h04, 32'd0);
        chk("lw_04_after_err", read_data, 32'h0000_0001);
        chk("err_pulse_clear", {31'd0, access_err}, 32'd0);
        req(1'b1, 1'b0, 3'b010, 32'h81, 32'd0);
        chk("prec_err", {31'd0, access_err}, 32'd1);
        chk("prec_mis", {31'd0, misaligned}, 32'd0);
        req(1'b1, 1'b0, 3'b110, 32'h00, 32'd0);
        chk("ld_f3_110_err", {31'd0, access_err}, 32'd1);

        // Read+write together is a store only; the next-cycle load sees it.
        req(1'b1, 1'b1, 3'b010, 32'h30, 32'h0000_0055);
        chk("rw_no_valid", {31'd0, rd_valid}, 32'd0);
        req(1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
        chk("lw_30", read_data, 32'h0000_0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
